// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - wormhole switch allocator with per-output round-robin lock
module switch_allocator #(
    parameter int          DST_W   = 3,
    parameter bit          LOCK_EN = 1'b1,
    parameter logic [2:0]  RR_INIT = 3'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           req_valid,
    input  logic [5*DST_W-1:0]   req_dst,
    input  logic [4:0]           req_tail,
    input  logic [4:0]           out_ready,
    output logic [4:0]           sel_N,
    output logic [4:0]           sel_S,
    output logic [4:0]           sel_E,
    output logic [4:0]           sel_W,
    output logic [4:0]           sel_L,
    output logic [4:0]           in_grant,
    output logic [4:0]           out_valid
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [4:0] state_q, state_d;
    logic [2:0] owner_q [5];
    logic [2:0] owner_d [5];
    logic [2:0] ptr_q   [5];
    logic [2:0] ptr_d   [5];
    logic [4:0] req_mat [5];
    logic [4:0] sel     [5];
    logic       xfer;

    function automatic logic [2:0] wrap_inc(input logic [2:0] v);
        return (v >= 3'd4) ? 3'd0 : v + 3'd1;
    endfunction

    // First requester at or above the pointer, wrapping 4 -> 0.
    function automatic logic [2:0] rr_pick(input logic [4:0] req, input logic [2:0] ptr);
        logic [2:0] idx;
        logic [2:0] win;
        logic       found;
        idx   = ptr;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
            idx = wrap_inc(idx);
        end
        return win;
    endfunction

    always_comb begin
        state_d   = state_q;
        in_grant  = 5'b0;
        out_valid = 5'b0;
        xfer      = 1'b0;
        for (int o = 0; o < 5; o++) begin
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            for (int i = 0; i < 5; i++) begin
                req_mat[o][i] = req_valid[i] && (req_dst[DST_W*i +: DST_W] == DST_W'(o));
            end
            sel[o] = (state_q[o] == ST_LOCKED) ? (5'b00001 << owner_q[o]) : 5'b0;
        end
        for (int o = 0; o < 5; o++) begin
            if (state_q[o] == ST_IDLE) begin
                if (|req_mat[o]) begin
                    state_d[o] = ST_LOCKED;
                    owner_d[o] = rr_pick(req_mat[o], ptr_q[o]);
                end
            end else begin
                out_valid[o] = req_mat[o][owner_q[o]];
                xfer         = out_valid[o] && out_ready[o];
                if (xfer) begin
                    in_grant[owner_q[o]] = 1'b1;
                    if (req_tail[owner_q[o]] || !LOCK_EN) begin
                        state_d[o] = ST_IDLE;
                        ptr_d[o]   = wrap_inc(owner_q[o]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= {5{ST_IDLE}};
            for (int o = 0; o < 5; o++) begin
                owner_q[o] <= 3'd0;
                ptr_q[o]   <= RR_INIT;
            end
        end else begin
            state_q <= state_d;
            for (int o = 0; o < 5; o++) begin
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

    assign sel_N = sel[0];
    assign sel_S = sel[1];
    assign sel_E = sel[2];
    assign sel_W = sel[3];
    assign sel_L = sel[4];

endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - directed self-checking bench for switch_allocator
module tb_switch_allocator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  req_valid = 5'b0;
    logic [14:0] req_dst = 15'b0;
    logic [4:0]  req_tail = 5'b0;
    logic [4:0]  out_ready = 5'b0;

    logic [4:0] n0, s0, e0, w0, l0, g0, v0;
    logic [4:0] n1, s1, e1, w1, l1, g1, v1;

    int         rem [5];
    logic [2:0] dst [5];
    bit         use_d1 = 1'b0;
    int         checks = 0;
    int         failures = 0;

    switch_allocator #(.DST_W(3), .LOCK_EN(1'b1), .RR_INIT(3'd0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_dst(req_dst),
        .req_tail(req_tail), .out_ready(out_ready),
        .sel_N(n0), .sel_S(s0), .sel_E(e0), .sel_W(w0), .sel_L(l0),
        .in_grant(g0), .out_valid(v0)
    );

    switch_allocator #(.DST_W(3), .LOCK_EN(1'b0), .RR_INIT(3'd0)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_dst(req_dst),
        .req_tail(req_tail), .out_ready(out_ready),
        .sel_N(n1), .sel_S(s1), .sel_E(e1), .sel_W(w1), .sel_L(l1),
        .in_grant(g1), .out_valid(v1)
    );

    always #5 clk = ~clk;

    task automatic apply();
        for (int i = 0; i < 5; i++) begin
            req_valid[i]       = (rem[i] > 0);
            req_tail[i]        = (rem[i] == 1);
            req_dst[3*i +: 3]  = dst[i];
        end
    endtask

    task automatic clear();
        for (int i = 0; i < 5; i++) begin
            rem[i] = 0;
            dst[i] = 3'd0;
        end
    endtask

    // Inputs pop on the grant seen just before the edge, then the next cycle is driven.
    task automatic step(input logic [4:0] rdy);
        logic [4:0] g;
        g = use_d1 ? g1 : g0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) if (g[i] && rem[i] > 0) rem[i] = rem[i] - 1;
        out_ready = rdy;
        apply();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear();
        apply();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rem[4] = 1; dst[4] = 3'd0; out_ready = 5'b11111;
        apply();
        @(negedge clk);
        checks++;
        if ({n0, s0, e0, w0, l0} !== 25'b0) begin
            failures++; $display("FAIL reset_sel got=%h exp=0", {n0, s0, e0, w0, l0});
        end
        checks++;
        if (g0 !== 5'b0 || v0 !== 5'b0) begin
            failures++; $display("FAIL reset_grant_valid grant=%b valid=%b exp=0", g0, v0);
        end
        clear();
        apply();
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        rem[4] = 1; dst[4] = 3'd0; out_ready = 5'b11111;
        apply();
        #1;
        checks++;
        if (n0 !== 5'b0 || g0 !== 5'b0) begin
            failures++; $display("FAIL single_c0 sel_N=%b grant=%b exp=0", n0, g0);
        end
        step(5'b11111);
        checks++;
        if (n0 !== 5'b10000) begin failures++; $display("FAIL single_c1_sel got=%b exp=10000", n0); end
        checks++;
        if (g0 !== 5'b10000) begin failures++; $display("FAIL single_c1_grant got=%b exp=10000", g0); end
        checks++;
        if (v0 !== 5'b00001) begin failures++; $display("FAIL single_c1_valid got=%b exp=00001", v0); end
        step(5'b11111);
        checks++;
        if (n0 !== 5'b0) begin failures++; $display("FAIL single_c2_sel got=%b exp=0", n0); end
    endtask

    task automatic test_contention();
        logic [4:0] exp;
        int ngr;
        ngr = 0;
        for (int i = 0; i < 3; i++) begin rem[i] = 3; dst[i] = 3'd2; end
        out_ready = 5'b11111;
        apply();
        #1;
        for (int c = 0; c <= 12; c++) begin
            exp = (c % 4 == 0) ? 5'b0 : (5'b00001 << (c / 4));
            checks++;
            if (e0 !== exp) begin failures++; $display("FAIL contention_sel c=%0d got=%b exp=%b", c, e0, exp); end
            checks++;
            if (g0 !== exp) begin failures++; $display("FAIL contention_grant c=%0d got=%b exp=%b", c, g0, exp); end
            if (g0 != 5'b0) ngr++;
            if (c < 12) step(5'b11111);
        end
        checks++;
        if (ngr != 9) begin failures++; $display("FAIL contention_count got=%0d exp=9", ngr); end
    endtask

    task automatic test_backpressure();
        logic [4:0] exp_sel, exp_g, rdy;
        int ngr;
        ngr = 0;
        clear();
        rem[1] = 4; dst[1] = 3'd3; out_ready = 5'b11111;
        apply();
        #1;
        for (int c = 0; c <= 8; c++) begin
            exp_sel = (c == 0 || c == 8) ? 5'b0 : 5'b00010;
            exp_g   = (c == 1 || c == 5 || c == 6 || c == 7) ? 5'b00010 : 5'b0;
            checks++;
            if (w0 !== exp_sel) begin failures++; $display("FAIL bp_sel c=%0d got=%b exp=%b", c, w0, exp_sel); end
            checks++;
            if (g0 !== exp_g) begin failures++; $display("FAIL bp_grant c=%0d got=%b exp=%b", c, g0, exp_g); end
            if (g0[1]) ngr++;
            rdy = (c + 1 >= 2 && c + 1 <= 4) ? 5'b10111 : 5'b11111;
            if (c < 8) step(rdy);
        end
        checks++;
        if (ngr != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", ngr); end
    endtask

    task automatic test_parallel();
        clear();
        dst[0] = 3'd1; dst[1] = 3'd0; dst[2] = 3'd3; dst[3] = 3'd2; dst[4] = 3'd4;
        for (int i = 0; i < 5; i++) rem[i] = 2;
        out_ready = 5'b11111;
        apply();
        #1;
        checks++;
        if ({n0, s0, e0, w0, l0} !== 25'b0) begin
            failures++; $display("FAIL par_c0 got=%h exp=0", {n0, s0, e0, w0, l0});
        end
        for (int c = 1; c <= 2; c++) begin
            step(5'b11111);
            checks++;
            if ({n0, s0, e0, w0, l0} !== {5'b00010, 5'b00001, 5'b01000, 5'b00100, 5'b10000}) begin
                failures++; $display("FAIL par_sel c=%0d got=%h exp=%h", c, {n0, s0, e0, w0, l0},
                    {5'b00010, 5'b00001, 5'b01000, 5'b00100, 5'b10000});
            end
            checks++;
            if (g0 !== 5'b11111) begin failures++; $display("FAIL par_grant c=%0d got=%b exp=11111", c, g0); end
        end
        step(5'b11111);
        checks++;
        if (g0 !== 5'b0 || {n0, s0, e0, w0, l0} !== 25'b0) begin
            failures++; $display("FAIL par_release grant=%b sel=%h exp=0", g0, {n0, s0, e0, w0, l0});
        end
    endtask

    task automatic test_async_reset();
        int guard;
        clear();
        rem[1] = 3; rem[2] = 3;
        out_ready = 5'b11111;
        apply();
        step(5'b11111);
        checks++;
        if (n0 !== 5'b00100) begin failures++; $display("FAIL ar_pre_sel got=%b exp=00100", n0); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({n0, s0, e0, w0, l0} !== 25'b0 || g0 !== 5'b0 || v0 !== 5'b0) begin
            failures++; $display("FAIL ar_immediate sel=%h grant=%b valid=%b exp=0", {n0, s0, e0, w0, l0}, g0, v0);
        end
        @(negedge clk);
        reset = 1'b1;
        rem[1] = 2; rem[2] = 2;
        apply();
        #1;
        checks++;
        if (n0 !== 5'b0) begin failures++; $display("FAIL ar_restart_c0 got=%b exp=0", n0); end
        step(5'b11111);
        checks++;
        if (n0 !== 5'b00010) begin failures++; $display("FAIL ar_restart_ptr got=%b exp=00010", n0); end
        guard = 0;
        while ((rem[1] > 0 || rem[2] > 0) && guard < 20) begin
            step(5'b11111);
            guard++;
        end
        checks++;
        if (rem[1] != 0 || rem[2] != 0) begin
            failures++; $display("FAIL ar_drain timeout rem1=%0d rem2=%0d exp=0", rem[1], rem[2]);
        end
    endtask

    task automatic test_lock_en_off();
        logic [4:0] exp;
        do_reset();
        use_d1 = 1'b1;
        rem[0] = 2; dst[0] = 3'd4; rem[3] = 2; dst[3] = 3'd4;
        out_ready = 5'b11111;
        apply();
        #1;
        for (int c = 0; c <= 8; c++) begin
            exp = (c % 2 == 0) ? 5'b0 : ((c % 4 == 1) ? 5'b00001 : 5'b01000);
            checks++;
            if (g1 !== exp) begin failures++; $display("FAIL nolock_grant c=%0d got=%b exp=%b", c, g1, exp); end
            checks++;
            if (l1 !== exp) begin failures++; $display("FAIL nolock_sel c=%0d got=%b exp=%b", c, l1, exp); end
            if (c < 8) step(5'b11111);
        end
        use_d1 = 1'b0;
    endtask

    task automatic test_invalid_dst();
        do_reset();
        rem[2] = 50; dst[2] = 3'd6;
        rem[0] = 2;  dst[0] = 3'd1;
        out_ready = 5'b11111;
        apply();
        #1;
        for (int c = 0; c <= 5; c++) begin
            checks++;
            if ({n0[2], s0[2], e0[2], w0[2], l0[2], g0[2]} !== 6'b0) begin
                failures++; $display("FAIL invalid_dst c=%0d sel_bits=%b grant=%b exp=0",
                    c, {n0[2], s0[2], e0[2], w0[2], l0[2]}, g0[2]);
            end
            if (c == 1) begin
                checks++;
                if (s0 !== 5'b00001) begin failures++; $display("FAIL invalid_other_sel got=%b exp=00001", s0); end
            end
            if (c < 5) step(5'b11111);
        end
        clear();
        apply();
    endtask

    initial begin
        clear();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_parallel();
        test_async_reset();
        test_lock_en_off();
        test_invalid_dst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Wormhole switch allocator that drives the five one-hot select buses of the 5-port (N,S,E,W,L) 64-bit router crossbar.
- Each output port has its own round-robin arbiter. The arbiter grants one input and locks the output to that input until the packet's tail flit has been transferred.
- The block sits beside the crossbar inside the router. Input buffers present requests to it, and it returns per-input grants.

Parameters:
- DST_W, 3, width of the per-input destination code (0=N, 1=S, 2=E, 3=W, 4=L; codes 5-7 are invalid).
- LOCK_EN, 1, 1 = hold the output for the whole packet until the tail flit; 0 = re-arbitrate after every flit.
- RR_INIT, 0, round-robin pointer value loaded at reset (0..4).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  5  bit i = input i (0=N..4=L) holds a valid head or body flit.
- req_dst  input  15  bits [3i+2:3i] = destination output code of input i.
- req_tail  input  5  bit i = current flit of input i is the tail.
- out_ready  input  5  bit o = downstream of output o can accept a flit this cycle.
- sel_N  output  5  one-hot crossbar select for output N (bit i = input i); 0 = idle.
- sel_S  output  5  crossbar select for output S.
- sel_E  output  5  crossbar select for output E.
- sel_W  output  5  crossbar select for output W.
- sel_L  output  5  crossbar select for output L.
- in_grant  output  5  bit i = the flit of input i is consumed this cycle (input pops on it).
- out_valid  output  5  bit o = the data on crossbar output o is a valid flit this cycle.

Behaviour:
- Per-output FSM, states IDLE and LOCKED, plus a 3-bit owner register and a 3-bit RR pointer.
- Reset (async, reset==0):
  - all FSMs go to IDLE, owners = 0, pointers = RR_INIT;
  - sel_* = 0, in_grant = 0, out_valid = 0;
  - a reset mid-packet drops the lock immediately.
- Request formation: input i requests output o when req_valid[i] && req_dst[i]==o. Invalid codes (5-7) request nothing and are never granted. Each input requests at most one output, so no cross-output conflict exists.
- IDLE -> LOCKED:
  - an output in IDLE with at least one requester picks the first requester searching upward (mod 5) from the pointer;
  - arbitration occurs regardless of out_ready;
  - at the next rising edge: state=LOCKED, owner=winner, sel_o = one-hot(winner).
  - Allocation latency is 1 cycle, and no flit transfers in the arbitration cycle.
- LOCKED:
  - sel_o = one-hot(owner), registered and stable;
  - out_valid[o] = req_valid[owner] && req_dst[owner]==o (combinational);
  - transfer = out_valid[o] && out_ready[o];
  - in_grant[owner] = transfer (combinational; at most one grant per input).
- Release:
  - on a transfer with req_tail[owner]==1, or on any transfer when LOCK_EN==0, the FSM returns to IDLE at the next edge;
  - on release, pointer = (owner+1) mod 5 and sel_o = 0.
  - No back-to-back regrant: there is always one IDLE cycle between packets on an output.
- Stalls: out_ready=0 or req_valid[owner]=0 while LOCKED holds the lock and sel, with no transfer.
- A U-turn (dst == own port) is permitted; it is the loopback path for L.
- Pointer arithmetic wraps at 4 -> 0.

Test Plan:
- Single-flit packet: reset, then req_valid[4]=1, req_dst[4]=0, req_tail[4]=1, out_ready=5'b11111 -> cycle 1: sel_N=5'b10000, in_grant=5'b10000, out_valid[0]=1; cycle 2: sel_N=0.
- Contention: inputs 0,1,2 all target E (dst=2), 3-flit packets, RR_INIT=0 -> grant order 0,1,2; sel_E=00001, then 00010, then 00100; each packet held for 3 transfers; never interleaved.
- Backpressure: locked 4-flit packet from S to W, out_ready[3]=0 for cycles 2-4 -> in_grant[1]=0 and sel_W=00010 held; exactly 4 grants total; release after the tail.
- Parallel outputs: N->S, S->N, E->W, W->E, L->L all at once -> all five sel_* one-hot in the same cycle; in_grant=11111 each cycle.
- LOCK_EN=0: inputs 0 and 3 both target L with multi-flit packets -> grants alternate per flit 0,3,0,3 with an IDLE cycle between each.
- Async reset asserted mid-packet (between clock edges) -> sel_*=0, in_grant=0, out_valid=0 immediately; after release, the pointer equals RR_INIT and arbitration restarts.
- Invalid dst=6 on input 2 -> input 2 is never granted; all sel_* bits for input 2 stay 0.
